pipelined_add_sub: RTL
======================

Name: pipelined_add_sub

Overview:
- Parametrised, pipelined WIDTH-bit two's-complement adder/subtracter for the ALU datapath.
- Splits the operands into STAGES equal chunks. Each chunk is added in its own register stage, and the carry ripples between stages.
- Valid/ready handshakes on both input and output. Reports carry, signed overflow and zero flags with every result.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH). Each stage processes CHUNK = WIDTH/STAGES bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  pipeline accepts the operand set this cycle.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- sub  input  1  0 = a+b, 1 = a-b.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH  sum/difference, mod 2^WIDTH.
- carry  output  1  carry out of the MSB. For subtraction, 1 = no borrow (a >= b unsigned).
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Subtraction is implemented as a + ~b + 1. The operand b is inverted when sub = 1, and sub is the carry-in of chunk 0.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b' plus the carry registered from stage k-1.
  - Registers its partial result, its carry, and the still-unprocessed upper chunks of a and b'.
  - Registers one valid bit.
- Global advance: advance = ~out_valid | out_ready.
  - in_ready = advance, combinational.
  - When advance = 1, every stage register loads from its predecessor. Stage 0 loads {in_valid, operands}.
  - When advance = 0, all stages hold their contents. Bubbles do not collapse.
- Latency: a transfer accepted at cycle t (in_valid & in_ready) appears with out_valid = 1 at cycle t+STAGES, provided advance stays 1 throughout.
- Throughput: one result per cycle while out_ready = 1.
- Output hold: result, carry, overflow and zero are registered in the last stage. They stay stable while out_valid & ~out_ready.
- Flags:
  - overflow = carry into the MSB XOR carry out of the MSB.
  - zero is computed over the full assembled result in the last stage.
- in_valid = 0 during an advance inserts a bubble (valid bit 0). Data in that bubble is don't-care but must be deterministic.
- Simultaneous output consume and input accept in the same cycle: both occur. No bubble is inserted and there is no combinational loop from in_valid to out_valid.
- Reset, asserted at any time including mid-flight:
  - All valid bits go to 0 immediately.
  - result, carry, overflow and zero go to 0; out_valid = 0.
  - in_ready = 1 after reset because out_valid = 0.
  - In-flight operations are discarded.
- STAGES = 1 degenerates to a single registered adder with latency 1.
- Wrap-around: results are modulo 2^WIDTH. No saturation.

Decomposition:
- Shared definitions file holds the op encodings (OP_ADD = 1'b0, OP_SUB = 1'b1). These encodings are reused by the ALU decoder.
- One sub-module, chunk_adder: combinational, CHUNK-bit ripple adder.
  - Inputs a, b, c_in.
  - Outputs sum, c_out, and c_msb_in (carry into its top bit, used for overflow in the last stage).
  - Instantiated STAGES times via generate.
- pipelined_add_sub owns only the registers and the handshake.

Test Plan (WIDTH=8, STAGES=2 unless noted):
- a=0x7F, b=0x01, sub=0, out_ready=1 -> after 2 cycles result=0x80, overflow=1, carry=0, zero=0.
- a=0x05, b=0x05, sub=1 -> result=0x00, zero=1, carry=1, overflow=0. Then a=0x00, b=0x01, sub=1 -> result=0xFF, carry=0, overflow=0.
- Back-to-back, 4 consecutive transfers with out_ready=1: inputs (0x10+0x20), (0xF0+0x20), (0x80-0x01), (0x01+0x01) -> outputs 0x30, 0x10 (carry=1), 0x7F (overflow=1), 0x02 on consecutive cycles with no gaps.
- Backpressure: out_ready=0 while out_valid=1 for 3 cycles, in_valid held high -> in_ready=0, result and flags stable, no transfer lost or duplicated after out_ready returns to 1.
- Reset mid-flight: accept 0x11+0x22, assert rst one cycle later -> out_valid=0 and result=0 immediately. After deassertion no stale result ever appears.
- WIDTH=32, STAGES=4, a=0xFFFFFFFF, b=0x00000001, sub=0 -> carry rippled through all stages: result=0, carry=1, zero=1, latency exactly 4.

Source files
------------

// File: rtl/pipelined_add_sub_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_add_sub_pkg
// Shared definitions for the pipelined adder/subtracter and the ALU decoder.
//   OP_ADD / OP_SUB : encoding of the 'sub' operation select bit.
// ---------------------------------------------------------------------------
package pipelined_add_sub_pkg;

    typedef logic op_t;

    localparam op_t OP_ADD = 1'b0;
    localparam op_t OP_SUB = 1'b1;

endpackage

// File: rtl/pipelined_add_sub_chunk_adder.sv
// ---------------------------------------------------------------------------
// chunk_adder
// Combinational CHUNK-bit ripple-carry adder used once per pipeline stage.
// Ports:
//   i_a, i_b    : CHUNK-bit addends
//   i_c_in      : carry into bit 0
//   o_sum       : CHUNK-bit sum
//   o_c_out     : carry out of the top bit
//   o_c_msb_in  : carry into the top bit (signed-overflow detection)
// ---------------------------------------------------------------------------
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_c_in,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_c_out,
    output logic             o_c_msb_in
);

    logic [CHUNK:0] w_carry;

    always_comb begin
        w_carry    = '0;
        o_sum      = '0;
        w_carry[0] = i_c_in;
        for (int i = 0; i < CHUNK; i++) begin
            o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
            w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_c_out    = w_carry[CHUNK];
    assign o_c_msb_in = w_carry[CHUNK-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// ---------------------------------------------------------------------------
// pipelined_add_sub
// Pipelined WIDTH-bit two's-complement adder/subtracter. The operands are cut
// into STAGES chunks of CHUNK bits; stage k adds chunk k and passes its carry
// to stage k+1. Latency is STAGES cycles, throughput one result per cycle.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready = ~out_valid | out_ready)
//   a, b, sub            : operands and operation (OP_ADD / OP_SUB)
//   out_valid / out_ready: result handshake
//   result               : a +/- b modulo 2^WIDTH
//   carry                : carry out of MSB (for subtraction 1 = no borrow)
//   overflow             : signed overflow
//   zero                 : result == 0
// ---------------------------------------------------------------------------
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_in0;

    // The whole pipe moves as one: a stalled output freezes every stage, so
    // bubbles are kept in place rather than squeezed out.
    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance;

    // a - b is computed as a + ~b + 1, the +1 entering as carry into chunk 0.
    assign w_b_eff = (sub == OP_SUB) ? ~b : b;
    assign w_c_in0 = (sub == OP_SUB);

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        // Operand bits still pending at this stage (this chunk and above) and
        // result bits assembled once this stage has added its chunk.
        localparam int IN_W  = WIDTH - gi * CHUNK;
        localparam int SUM_W = (gi + 1) * CHUNK;

        logic [IN_W-1:0]  w_a_in;
        logic [IN_W-1:0]  w_b_in;
        logic             w_c_in;
        logic             w_v_in;
        logic [CHUNK-1:0] w_sum_chunk;
        logic             w_c_out;
        logic [SUM_W-1:0] w_sum_next;

        logic             r_v;
        logic             r_c;
        logic [SUM_W-1:0] r_sum;

        if (gi == 0) begin : g_first
            assign w_a_in     = a;
            assign w_b_in     = w_b_eff;
            assign w_c_in     = w_c_in0;
            assign w_v_in     = in_valid;
            assign w_sum_next = w_sum_chunk;
        end else begin : g_next
            assign w_a_in     = g_stage[gi-1].g_fwd.r_a;
            assign w_b_in     = g_stage[gi-1].g_fwd.r_b;
            assign w_c_in     = g_stage[gi-1].r_c;
            assign w_v_in     = g_stage[gi-1].r_v;
            assign w_sum_next = {w_sum_chunk, g_stage[gi-1].r_sum};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (w_advance) begin
                r_v   <= w_v_in;
                r_c   <= w_c_out;
                r_sum <= w_sum_next;
            end
        end

        if (gi < STAGES - 1) begin : g_fwd
            // Upper operand chunks travel alongside the partial sum.
            logic             w_c_msb_unused;
            logic [IN_W-CHUNK-1:0] r_a;
            logic [IN_W-CHUNK-1:0] r_b;

            chunk_adder #(.CHUNK(CHUNK)) u_chunk (
                .i_a        (w_a_in[CHUNK-1:0]),
                .i_b        (w_b_in[CHUNK-1:0]),
                .i_c_in     (w_c_in),
                .o_sum      (w_sum_chunk),
                .o_c_out    (w_c_out),
                .o_c_msb_in (w_c_msb_unused)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_advance) begin
                    r_a <= w_a_in[IN_W-1:CHUNK];
                    r_b <= w_b_in[IN_W-1:CHUNK];
                end
            end
        end else begin : g_last
            // Final chunk holds the MSB, so the flags are formed here.
            logic w_c_msb_in;
            logic r_ovf;
            logic r_zero;

            chunk_adder #(.CHUNK(CHUNK)) u_chunk (
                .i_a        (w_a_in[CHUNK-1:0]),
                .i_b        (w_b_in[CHUNK-1:0]),
                .i_c_in     (w_c_in),
                .o_sum      (w_sum_chunk),
                .o_c_out    (w_c_out),
                .o_c_msb_in (w_c_msb_in)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_advance) begin
                    r_ovf  <= w_c_msb_in ^ w_c_out;
                    r_zero <= (w_sum_next == '0);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_v;
    assign result    = g_stage[STAGES-1].r_sum;
    assign carry     = g_stage[STAGES-1].r_c;
    assign overflow  = g_stage[STAGES-1].g_last.r_ovf;
    assign zero      = g_stage[STAGES-1].g_last.r_zero;

endmodule
